// File: rtl/tis_port_fifo.sv
// tis_port_fifo: blocking-handshake word FIFO between node ports with saturating stall counters
module tis_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [15:0]      wr_stall_cnt,
  output logic [15:0]      rd_stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0, ACK = 1'b1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [0:0] state;
  logic push, pop, wrStall, rdStall;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd_valid = ~empty;
  assign rd_data = empty ? '0 : mem[rp];
  assign wr_ack = state == ACK;
  assign push = state == IDLE && wr_valid && !full;
  assign pop = rd_req && rd_valid;
  assign wrStall = state == IDLE && wr_valid && full;
  assign rdStall = rd_req && empty;
  always_ff @(posedge clk)
    if (reset && push) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      state <= IDLE;
      wr_stall_cnt <= '0;
      rd_stall_cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      state <= push ? ACK : IDLE;
      wr_stall_cnt <= wr_stall_cnt + 16'(wrStall && wr_stall_cnt != 16'hFFFF);
      rd_stall_cnt <= rd_stall_cnt + 16'(rdStall && rd_stall_cnt != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_tis_port_fifo.sv
// tb_tis_port_fifo: queue-model bench with directed scenarios and random traffic
module tb_tis_port_fifo;
  logic clk = 0, reset = 0, wr_valid = 0, rd_req = 0;
  logic [7:0] wr_data = 0;
  logic wr_ack, rd_valid, full, empty;
  logic [7:0] rd_data;
  logic [2:0] count;
  logic [15:0] wr_stall_cnt, rd_stall_cnt;
  int vectors = 0, errs = 0;
  logic [7:0] q[$];
  bit mAck;
  int mWs, mRs;

  tis_port_fifo dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .full(full),
    .empty(empty), .wr_stall_cnt(wr_stall_cnt), .rd_stall_cnt(rd_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    chk("count", count, q.size());
    chk("full", full, q.size() == 4);
    chk("empty", empty, q.size() == 0);
    chk("rd_valid", rd_valid, q.size() != 0);
    chk("rd_data", rd_data, q.size() != 0 ? q[0] : 8'h00);
    chk("wr_ack", wr_ack, mAck);
    chk("wr_stall", wr_stall_cnt, mWs);
    chk("rd_stall", rd_stall_cnt, mRs);
  endtask

  task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic rs, input bit ck = 1);
    bit acc, pp;
    wr_valid = wv;
    wr_data = wd;
    rd_req = rr;
    reset = rs;
    if (!rs) begin
      q.delete();
      mAck = 0;
      mWs = 0;
      mRs = 0;
    end else begin
      acc = !mAck && wv && q.size() != 4;
      pp = rr && q.size() != 0;
      if (!mAck && wv && q.size() == 4 && mWs < 65535) mWs++;
      if (rr && q.size() == 0 && mRs < 65535) mRs++;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(wd);
      mAck = acc;
    end
    @(posedge clk);
    #1;
    if (ck) checkAll();
  endtask

  task automatic put(input logic [7:0] d);
    step(1, d, 0, 1);
    step(0, 0, 0, 1);
  endtask

  initial begin
    logic [7:0] exp4 [4];
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ack", wr_ack, 0);
    // single word
    step(1, 8'h5A, 0, 1);
    chk("single_ack", wr_ack, 1);
    chk("single_data", rd_data, 8'h5A);
    chk("single_count", count, 1);
    step(0, 0, 0, 1);
    chk("single_ack_drop", wr_ack, 0);
    step(0, 0, 1, 1);
    chk("single_empty", empty, 1);
    chk("single_zero", rd_data, 0);
    // fill, stall, wrap
    step(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) put(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h05, 0, 1);
      chk("stall_noack", wr_ack, 0);
    end
    chk("stall_cnt3", wr_stall_cnt, 3);
    chk("pop_head", rd_data, 8'h01);
    step(1, 8'h05, 1, 1);
    chk("full_pop_blocked", wr_ack, 0);
    step(1, 8'h05, 0, 1);
    chk("wrap_ack", wr_ack, 1);
    step(0, 0, 0, 1);
    exp4 = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", rd_data, exp4[i]);
      step(0, 0, 1, 1);
    end
    chk("drain_empty", empty, 1);
    // simultaneous push/pop at count 2
    step(0, 0, 0, 0);
    put(8'hA1);
    put(8'hB2);
    step(1, 8'hC3, 1, 1);
    chk("pp_count", count, 2);
    chk("pp_head", rd_data, 8'hB2);
    step(0, 0, 1, 1);
    chk("pp_next", rd_data, 8'hC3);
    // read while empty, then saturate
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    chk("rd_stall5", rd_stall_cnt, 5);
    for (int i = 0; i < 70000; i++) step(0, 0, 1, 1, 0);
    chk("rd_stall_sat", rd_stall_cnt, 16'hFFFF);
    checkAll();
    // reset in the ack cycle
    step(0, 0, 0, 0);
    put(8'h11);
    put(8'h22);
    step(1, 8'h33, 0, 1);
    chk("mid_ack", wr_ack, 1);
    chk("mid_count", count, 3);
    step(0, 0, 0, 0);
    chk("mid_ack_cancel", wr_ack, 0);
    chk("mid_count0", count, 0);
    chk("mid_empty", empty, 1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 99) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
